vga_scene_renderer: RTL and testbench
=====================================

Name: vga_scene_renderer

Overview:
Pipelined, parametrised successor to the combinational pixel colour generator. Draws the background colour, a ceiling band, a runtime-loadable table of coloured rectangles (platforms, lava, goal), a rising-lava column and a 16x16 player sprite. It also applies a game-state tint that fades in over several frames. It sits between the VGA timing generator (x, y, active_pixels, frame_start) and the DAC pins, and is loaded by the level controller through a simple write port instead of hard-coded per-level geometry.

Parameters:
NUM_RECTS, 16, number of rectangle slots in the scene table (2..64)
COORD_W, 10, width of x/y coordinates
CEIL_Y, 75, rows with y < CEIL_Y are drawn DARK_GRAY when no rectangle covers them
FADE_SHIFT, 3, fade resolution; fade_level runs 0..2**FADE_SHIFT
BG_COLOR, 24'hC0C0C0, background colour
PLAYER_COLOR, 24'h0000FF, sprite foreground colour

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
x  in  COORD_W  current pixel column
y  in  COORD_W  current pixel row
active_pixels  in  1  visible-area qualifier
frame_start  in  1  one-cycle pulse at the start of each frame
player_x, player_y  in  COORD_W each  sprite top-left corner
lava_x  in  COORD_W  left edge of the rising-lava column; the column is 40 px wide
lava_height  in  COORD_W  height of the lava column measured up from row 480
game_state  in  3  0 RUNNING, 1 GAME_OVER, 2 WIN, others treated as RUNNING
wr_en  in  1  write one rectangle slot
wr_idx  in  $clog2(NUM_RECTS)  slot index
wr_x0, wr_x1, wr_y0, wr_y1  in  COORD_W each  inclusive bounds
wr_color  in  24  slot colour
wr_valid  in  1  slot enable bit written with the slot
clear_all  in  1  invalidate all slots
VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
out_active  out  1  active_pixels delayed to align with the colour outputs

Behaviour:
- Reset: all slot valid bits = 0; fade_level = 0; VGA_R/G/B = 0; out_active = 0; all pipeline registers = 0.
- Latency is exactly 3 clk from x/y/active_pixels to VGA_*/out_active. All pixel inputs, including player_*, lava_* and game_state, are sampled in stage 0.
  - S1: parallel hit compare per slot (x0<=x<=x1 and y0<=y<=y1 and valid); sprite-box hit; lava hit (x in [lava_x, lava_x+40) and y >= 480-lava_height); ceiling hit.
  - S2: priority select. Order, lowest to highest: BG, ceiling, slots (a higher index overrides a lower index), lava column, sprite pixel. Sprite pattern as the stick figure: head px 5..10 with py<=5; body px 7..8 with py 6..12; legs diagonals for py 8..12 and py 13..15.
  - S3: tint, then register outputs. If the delayed active_pixels = 0, outputs are 0.
- Sprite bounds use COORD_W+1-bit sums, so player_x near 1023 must not wrap. The same applies to lava_x+40 and wr bounds.
- Table write: takes effect on the cycle after wr_en. A write mid-frame may tear; this is accepted.
  - clear_all and wr_en in the same cycle: clear_all wins; the write is dropped.
  - A slot with x0>x1 or y0>y1 never hits.
- Fade FSM (states IDLE, FADING, HELD):
  - In IDLE, fade_level=0.
  - On frame_start with game_state GAME_OVER or WIN, go to FADING and latch the tint target state.
  - On each frame_start in FADING, fade_level+1. At 2**FADE_SHIFT, go to HELD.
  - If game_state returns to RUNNING, go to IDLE with fade_level=0 on the next clk; this does not wait for frame_start.
  - If game_state changes between GAME_OVER and WIN, restart at fade_level=0 with the new target.
- Tint arithmetic, per channel:
  - GAME_OVER target = {R|8'h60, G>>1, B>>1}; WIN target = base | 24'h302000.
  - out = base + (((target-base) * fade_level) >>> FADE_SHIFT), using a signed 9-bit diff and a signed product.
  - The result is clamped to 0..255. At the full fade level, out equals target exactly.

Optional Feature:
SPRITE_MIRROR_EN. When defined, adds input player_dir (1 bit, 1 = facing left). When player_dir=1 the sprite is mirrored horizontally, px' = 15-px, sampled in stage 0. When undefined, the port does not exist and the sprite is never mirrored.

Decomposition:
- Package vga_scene_pkg: game_state encodings, colour constants (LIGHT_GRAY, DARK_GRAY, LAVA_RED, GOLD, GRASS_GREEN, LAVA_WALL_COLOR), LAVA_WIDTH=40, SCREEN_H=480, SPRITE_SIZE=16, and a rect_t struct {valid, x0, x1, y0, y1, color}.
- One sub-module, vga_tint_fade: the fade FSM plus the per-channel blend datapath.

Test Plan:
- Reset, then drive x=10,y=100,active=1 -> after 3 clk VGA = C0,C0,C0 and out_active=1; with active=0, VGA = 0,0,0.
- Write slot3 {0,60,360,380,3CB043} and slot5 {50,100,350,370,505050}; pixel (55,365) -> 50,50,50. Pixel (20,370) -> 3C,B0,43. Assert clear_all together with wr_en on slot3 -> slot3 stays invalid.
- player=(100,200); pixel (107,210) -> 00,00,FF; pixel (100,215) -> background. With SPRITE_MIRROR_EN and player_dir=1, pixel (115,200) -> background and (110,200) -> 00,00,FF.
- lava_x=270, lava_height=100; pixel (270,380) -> FF,45,00; pixel (310,380) -> background; pixel (269,479) -> background.
- game_state=GAME_OVER, 8 frame_starts on a BG pixel -> R steps C0..E0; full-fade output = E0,60,60, held thereafter. Setting RUNNING -> C0,C0,C0 within 4 clk.
- player_x=1020 -> no sprite hit at x=0..3 (no wrap). GAME_OVER->WIN mid-fade -> fade restarts at 0; after 8 frames, output = F0,E0,C0.

Source files
------------

// File: rtl/vga_scene_pkg.sv
// Shared definitions for the VGA scene renderer: game-state codes, palette,
// scene geometry constants, the rectangle-slot record and the sprite bitmap.
// Zero latency (constants, types and one combinational helper); no flow control.
package vga_scene_pkg;

    // Game-state encodings driven by the level controller
    localparam logic [2:0] GS_RUNNING   = 3'd0;
    localparam logic [2:0] GS_GAME_OVER = 3'd1;
    localparam logic [2:0] GS_WIN       = 3'd2;

    // Palette
    localparam logic [23:0] LIGHT_GRAY      = 24'hC0C0C0;
    localparam logic [23:0] DARK_GRAY       = 24'h404040;
    localparam logic [23:0] LAVA_RED        = 24'hFF0000;
    localparam logic [23:0] GOLD            = 24'hFFD700;
    localparam logic [23:0] GRASS_GREEN     = 24'h3CB043;
    localparam logic [23:0] LAVA_WALL_COLOR = 24'hFF4500;

    // Scene geometry
    localparam int LAVA_WIDTH  = 40;
    localparam int SCREEN_H    = 480;
    localparam int SPRITE_SIZE = 16;

    // Slot bounds are stored at a fixed width wide enough for any COORD_W up to 16
    localparam int MAX_COORD_W = 16;

    typedef struct packed {
        logic                   valid;
        logic [MAX_COORD_W-1:0] x0;
        logic [MAX_COORD_W-1:0] x1;
        logic [MAX_COORD_W-1:0] y0;
        logic [MAX_COORD_W-1:0] y1;
        logic [23:0]            color;
    } rect_t;

    typedef enum logic [1:0] {
        FADE_IDLE   = 2'd0,
        FADE_FADING = 2'd1,
        FADE_HELD   = 2'd2
    } fade_state_e;

    // Stick figure, 16x16, px/py relative to the sprite top-left corner.
    // Head block, a two-pixel body, and a pair of diagonals (arms then legs)
    // spreading outward from the body for rows 8..15.
    function automatic logic sprite_pixel(input logic [3:0] px, input logic [3:0] py);
        logic head;
        logic body;
        logic limbs;
        head  = (px >= 4'd5) && (px <= 4'd10) && (py <= 4'd5);
        body  = ((px == 4'd7) || (px == 4'd8)) && (py >= 4'd6) && (py <= 4'd12);
        limbs = (py >= 4'd8) &&
                (({1'b0, px} == (5'd16 - {1'b0, py})) || (px == (py - 4'd1)));
        return head || body || limbs;
    endfunction

endpackage

// File: rtl/vga_tint_fade.sv
// Game-state tint: fade FSM stepping once per frame plus the per-channel blend.
// Blend is combinational (0 clk); fade level updates on frame_start or game_state change.
// No backpressure: consumes one colour per clock, always ready.
//
// Ports: clk, rst (sync, active high), frame_start, game_state,
//        base_color (colour before tint) -> tint_color (blended colour).
module vga_tint_fade
    import vga_scene_pkg::*;
#(
    parameter int FADE_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [2:0]  game_state,
    input  logic [23:0] base_color,
    output logic [23:0] tint_color
);

    localparam logic [FADE_SHIFT:0] LVL_ONE  = (FADE_SHIFT+1)'(1);
    localparam logic [FADE_SHIFT:0] LVL_FULL = (FADE_SHIFT+1)'(1 << FADE_SHIFT);
    localparam int                  BW       = FADE_SHIFT + 11;

    fade_state_e         state_q, state_d;
    logic [FADE_SHIFT:0] level_q, level_d;
    logic                win_q, win_d;      // latched tint target: 1 = WIN, 0 = GAME_OVER
    logic                gs_win;
    logic                gs_end;
    logic [FADE_SHIFT:0] level_inc;
    logic [23:0]         target;

    assign gs_win    = (game_state == GS_WIN);
    assign gs_end    = (game_state == GS_GAME_OVER) || gs_win;
    assign level_inc = level_q + LVL_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FADE_IDLE;
            level_q <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        win_d   = win_q;
        if (!gs_end) begin
            // Back to play: drop the tint immediately, no frame sync
            state_d = FADE_IDLE;
            level_d = '0;
        end else if ((state_q != FADE_IDLE) && (gs_win != win_q)) begin
            // GAME_OVER <-> WIN swap restarts the fade toward the new target
            state_d = FADE_FADING;
            level_d = '0;
            win_d   = gs_win;
        end else if (frame_start) begin
            case (state_q)
                FADE_IDLE: begin
                    state_d = FADE_FADING;
                    level_d = '0;
                    win_d   = gs_win;
                end
                FADE_FADING: begin
                    level_d = level_inc;
                    if (level_inc == LVL_FULL) begin
                        state_d = FADE_HELD;
                    end
                end
                default: ;
            endcase
        end
    end

    // base + ((target - base) * level) >>> FADE_SHIFT; at full level the
    // product is an exact multiple of 2**FADE_SHIFT so the result hits target.
    function automatic logic [7:0] blend(input logic [7:0] b, input logic [7:0] t,
                                         input logic [FADE_SHIFT:0] lvl);
        logic signed [8:0]    diff;
        logic signed [BW-1:0] prod;
        logic signed [BW-1:0] sum;
        logic [7:0]           res;
        diff = $signed({1'b0, t}) - $signed({1'b0, b});
        prod = BW'(diff) * BW'($signed({1'b0, lvl}));
        sum  = (prod >>> FADE_SHIFT) + BW'($signed({1'b0, b}));
        if (sum[BW-1]) begin
            res = 8'd0;
        end else if (sum > BW'(255)) begin
            res = 8'hFF;
        end else begin
            res = sum[7:0];
        end
        return res;
    endfunction

    always_comb begin
        if (win_q) begin
            target = base_color | 24'h302000;
        end else begin
            target = {base_color[23:16] | 8'h60, 1'b0, base_color[15:9], 1'b0, base_color[7:1]};
        end
        tint_color = {blend(base_color[23:16], target[23:16], level_q),
                      blend(base_color[15:8],  target[15:8],  level_q),
                      blend(base_color[7:0],   target[7:0],   level_q)};
    end

endmodule

// File: rtl/vga_scene_renderer.sv
// Pipelined pixel colour generator: BG, ceiling, rectangle table, lava column, sprite, tint.
// Latency 3 clk from x/y/active_pixels to VGA_*/out_active.
// No backpressure: one pixel accepted and produced every clock.
//
// Ports: pixel stream in (x, y, active_pixels, frame_start), scene state
// (player_*, lava_*, game_state), slot write port (wr_*, clear_all),
// DAC out (VGA_R/G/B, out_active). Build option SPRITE_MIRROR_EN adds
// player_dir (1 = facing left) which mirrors the sprite horizontally.
module vga_scene_renderer
    import vga_scene_pkg::*;
#(
    parameter int          NUM_RECTS    = 16,
    parameter int          COORD_W      = 10,
    parameter int          CEIL_Y       = 75,
    parameter int          FADE_SHIFT   = 3,
    parameter logic [23:0] BG_COLOR     = LIGHT_GRAY,
    parameter logic [23:0] PLAYER_COLOR = 24'h0000FF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [COORD_W-1:0]           x,
    input  logic [COORD_W-1:0]           y,
    input  logic                         active_pixels,
    input  logic                         frame_start,
    input  logic [COORD_W-1:0]           player_x,
    input  logic [COORD_W-1:0]           player_y,
    input  logic [COORD_W-1:0]           lava_x,
    input  logic [COORD_W-1:0]           lava_height,
    input  logic [2:0]                   game_state,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_RECTS)-1:0] wr_idx,
    input  logic [COORD_W-1:0]           wr_x0,
    input  logic [COORD_W-1:0]           wr_x1,
    input  logic [COORD_W-1:0]           wr_y0,
    input  logic [COORD_W-1:0]           wr_y1,
    input  logic [23:0]                  wr_color,
    input  logic                         wr_valid,
    input  logic                         clear_all,
`ifdef SPRITE_MIRROR_EN
    input  logic                         player_dir,
`endif
    output logic [7:0]                   VGA_R,
    output logic [7:0]                   VGA_G,
    output logic [7:0]                   VGA_B,
    output logic                         out_active
);

    // ---------------- scene table ----------------
    rect_t rect_q [NUM_RECTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RECTS; i++) rect_q[i] <= '0;
        end else if (clear_all) begin
            // clear_all beats a same-cycle write
            for (int i = 0; i < NUM_RECTS; i++) rect_q[i].valid <= 1'b0;
        end else if (wr_en && (int'(wr_idx) < NUM_RECTS)) begin
            rect_q[wr_idx] <= '{valid: wr_valid,
                                x0:    MAX_COORD_W'(wr_x0),
                                x1:    MAX_COORD_W'(wr_x1),
                                y0:    MAX_COORD_W'(wr_y0),
                                y1:    MAX_COORD_W'(wr_y1),
                                color: wr_color};
        end
    end

    // ---------------- stage 1: hit tests ----------------
    logic [MAX_COORD_W-1:0] xw, yw;
    logic [NUM_RECTS-1:0]   hit_d, hit_q;
    logic [COORD_W:0]       spr_x_end, spr_y_end, lava_x_end, lava_y_sum;
    logic                   spr_box_d, spr_box_q;
    logic                   lava_d, lava_q;
    logic                   ceil_d, ceil_q;
    logic [3:0]             px_raw, px_d, px_q, py_d, py_q;
    logic                   act1_q;

    assign xw = MAX_COORD_W'(x);
    assign yw = MAX_COORD_W'(y);

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            hit_d[i] = rect_q[i].valid &&
                       (xw >= rect_q[i].x0) && (xw <= rect_q[i].x1) &&
                       (yw >= rect_q[i].y0) && (yw <= rect_q[i].y1);
        end
    end

    // One extra bit on the far edges so a box near the right/bottom limit cannot wrap
    assign spr_x_end  = {1'b0, player_x} + (COORD_W+1)'(SPRITE_SIZE);
    assign spr_y_end  = {1'b0, player_y} + (COORD_W+1)'(SPRITE_SIZE);
    assign lava_x_end = {1'b0, lava_x}   + (COORD_W+1)'(LAVA_WIDTH);
    // y >= SCREEN_H - lava_height rewritten as a sum so tall lava cannot underflow
    assign lava_y_sum = {1'b0, y} + {1'b0, lava_height};

    assign spr_box_d = (x >= player_x) && ({1'b0, x} < spr_x_end) &&
                       (y >= player_y) && ({1'b0, y} < spr_y_end);
    assign lava_d    = (x >= lava_x) && ({1'b0, x} < lava_x_end) &&
                       (lava_y_sum >= (COORD_W+1)'(SCREEN_H));
    assign ceil_d    = (y < COORD_W'(CEIL_Y));

    // Sprite is 16 wide, so the low nibble difference is the in-sprite offset
    assign px_raw = x[3:0] - player_x[3:0];
    assign py_d   = y[3:0] - player_y[3:0];
`ifdef SPRITE_MIRROR_EN
    assign px_d   = player_dir ? (4'd15 - px_raw) : px_raw;
`else
    assign px_d   = px_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q     <= '0;
            spr_box_q <= 1'b0;
            lava_q    <= 1'b0;
            ceil_q    <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            act1_q    <= 1'b0;
        end else begin
            hit_q     <= hit_d;
            spr_box_q <= spr_box_d;
            lava_q    <= lava_d;
            ceil_q    <= ceil_d;
            px_q      <= px_d;
            py_q      <= py_d;
            act1_q    <= active_pixels;
        end
    end

    // ---------------- stage 2: priority select ----------------
    logic [23:0] color_d, color_q;
    logic        act2_q;

    always_comb begin
        color_d = BG_COLOR;
        if (ceil_q) color_d = DARK_GRAY;
        // Ascending scan: the highest-index hitting slot is the last to assign
        for (int i = 0; i < NUM_RECTS; i++) begin
            if (hit_q[i]) color_d = rect_q[i].color;
        end
        if (lava_q) color_d = LAVA_WALL_COLOR;
        if (spr_box_q && sprite_pixel(px_q, py_q)) color_d = PLAYER_COLOR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color_q <= '0;
            act2_q  <= 1'b0;
        end else begin
            color_q <= color_d;
            act2_q  <= act1_q;
        end
    end

    // ---------------- stage 3: tint and output ----------------
    logic [23:0] tint_w;
    logic [23:0] rgb_q;
    logic        act3_q;

    vga_tint_fade #(
        .FADE_SHIFT (FADE_SHIFT)
    ) u_tint (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .game_state  (game_state),
        .base_color  (color_q),
        .tint_color  (tint_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q  <= '0;
            act3_q <= 1'b0;
        end else begin
            rgb_q  <= act2_q ? tint_w : 24'h0;
            act3_q <= act2_q;
        end
    end

    assign VGA_R      = rgb_q[23:16];
    assign VGA_G      = rgb_q[15:8];
    assign VGA_B      = rgb_q[7:0];
    assign out_active = act3_q;

endmodule

// File: tb/tb_vga_scene_renderer.sv
// Self-checking bench for vga_scene_renderer: scene/tint model plus directed pixels.
// Model output is compared every cycle; directed pixels carry literal expectations.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_vga_scene_renderer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  x, y, player_x, player_y, lava_x, lava_height;
    logic        active_pixels, frame_start;
    logic [2:0]  game_state;
    logic        wr_en, wr_valid, clear_all;
    logic [3:0]  wr_idx;
    logic [9:0]  wr_x0, wr_x1, wr_y0, wr_y1;
    logic [23:0] wr_color;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        out_active;
`ifdef SPRITE_MIRROR_EN
    logic        player_dir;
`endif

    vga_scene_renderer dut (
        .clk           (clk),
        .rst           (rst),
        .x             (x),
        .y             (y),
        .active_pixels (active_pixels),
        .frame_start   (frame_start),
        .player_x      (player_x),
        .player_y      (player_y),
        .lava_x        (lava_x),
        .lava_height   (lava_height),
        .game_state    (game_state),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_x0         (wr_x0),
        .wr_x1         (wr_x1),
        .wr_y0         (wr_y0),
        .wr_y1         (wr_y1),
        .wr_color      (wr_color),
        .wr_valid      (wr_valid),
        .clear_all     (clear_all),
`ifdef SPRITE_MIRROR_EN
        .player_dir    (player_dir),
`endif
        .VGA_R         (VGA_R),
        .VGA_G         (VGA_G),
        .VGA_B         (VGA_B),
        .out_active    (out_active)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- behavioural model ----------------
    bit          m_valid [16];
    int          m_x0 [16], m_x1 [16], m_y0 [16], m_y1 [16];
    logic [23:0] m_col [16];
    int          m_level;
    bit          m_fading, m_win;
    logic [24:0] pipe0, pipe1;       // {active, untinted colour}
    logic [23:0] exp_rgb;
    logic        exp_act;

    function automatic bit stick(int sx, int sy);
        bit head, body, limbs;
        head  = (sx >= 5 && sx <= 10 && sy <= 5);
        body  = (sx >= 7 && sx <= 8 && sy >= 6 && sy <= 12);
        limbs = (sy >= 8 && (sx == 16 - sy || sx == sy - 1));
        return head || body || limbs;
    endfunction

    function automatic logic [23:0] scene_color(int cx, int cy);
        logic [23:0] c;
        int sx, sy;
        c = 24'hC0C0C0;
        if (cy < 75) c = 24'h404040;
        for (int i = 0; i < 16; i++)
            if (m_valid[i] && cx >= m_x0[i] && cx <= m_x1[i] && cy >= m_y0[i] && cy <= m_y1[i])
                c = m_col[i];
        if (cx >= int'(lava_x) && cx < int'(lava_x) + 40 && cy >= 480 - int'(lava_height))
            c = 24'hFF4500;
        sx = cx - int'(player_x);
        sy = cy - int'(player_y);
        if (sx >= 0 && sx < 16 && sy >= 0 && sy < 16) begin
`ifdef SPRITE_MIRROR_EN
            if (player_dir) sx = 15 - sx;
`endif
            if (stick(sx, sy)) c = 24'h0000FF;
        end
        return c;
    endfunction

    function automatic logic [23:0] apply_tint(logic [23:0] c);
        logic [23:0] tgt, r;
        int b, t, o;
        if (m_win) tgt = c | 24'h302000;
        else       tgt = {c[23:16] | 8'h60, c[15:8] >> 1, c[7:0] >> 1};
        r = 24'h0;
        for (int ch = 0; ch < 3; ch++) begin
            b = int'(c[ch*8 +: 8]);
            t = int'(tgt[ch*8 +: 8]);
            o = b + (((t - b) * m_level) >>> 3);
            if (o < 0)   o = 0;
            if (o > 255) o = 255;
            r[ch*8 +: 8] = o[7:0];
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_x0[i] = 0; m_x1[i] = 0; m_y0[i] = 0; m_y1[i] = 0; m_col[i] = 24'h0;
            end
            m_level = 0; m_fading = 0; m_win = 0;
            pipe0 = '0; pipe1 = '0; exp_rgb = 24'h0; exp_act = 1'b0;
        end else begin
            exp_act = pipe1[24];
            exp_rgb = pipe1[24] ? apply_tint(pipe1[23:0]) : 24'h0;
            pipe1   = pipe0;
            pipe0   = {active_pixels, scene_color(int'(x), int'(y))};
            if (game_state != 3'd1 && game_state != 3'd2) begin
                m_fading = 0; m_level = 0;
            end else if (m_fading && ((game_state == 3'd2) != m_win)) begin
                m_level = 0; m_win = (game_state == 3'd2);
            end else if (frame_start) begin
                if (!m_fading) begin
                    m_fading = 1; m_level = 0; m_win = (game_state == 3'd2);
                end else if (m_level < 8) begin
                    m_level++;
                end
            end
            if (clear_all) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 0;
            end else if (wr_en) begin
                m_valid[wr_idx] = wr_valid;
                m_x0[wr_idx] = int'(wr_x0); m_x1[wr_idx] = int'(wr_x1);
                m_y0[wr_idx] = int'(wr_y0); m_y1[wr_idx] = int'(wr_y1);
                m_col[wr_idx] = wr_color;
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            n_chk++;
            if ({VGA_R, VGA_G, VGA_B} !== exp_rgb || out_active !== exp_act) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t: dut rgb=%h act=%b, model rgb=%h act=%b",
                         $time, {VGA_R, VGA_G, VGA_B}, out_active, exp_rgb, exp_act);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input logic [23:0] want, input logic want_act);
        n_chk++;
        if ({VGA_R, VGA_G, VGA_B} !== want || out_active !== want_act) begin
            n_fail++;
            $display("FAIL %s: dut rgb=%h act=%b, expected rgb=%h act=%b",
                     nm, {VGA_R, VGA_G, VGA_B}, out_active, want, want_act);
        end
        n_chk++;
        if (exp_rgb !== want || exp_act !== want_act) begin
            n_fail++;
            $display("FAIL %s(model): model rgb=%h act=%b, expected rgb=%h act=%b",
                     nm, exp_rgb, exp_act, want, want_act);
        end
    endtask

    task automatic settle_chk(input string nm, input logic [23:0] want);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(nm, want, 1'b1);
    endtask

    task automatic show(input string nm, input int px, input int py, input logic act,
                        input logic [23:0] want);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        active_pixels = act;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(nm, want, act);
    endtask

    task automatic wr_slot(input int idx, input int x0, input int x1, input int y0, input int y1,
                           input logic [23:0] col, input logic clr);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 4'(idx); wr_valid = 1'b1; clear_all = clr;
        wr_x0 = 10'(x0); wr_x1 = 10'(x1); wr_y0 = 10'(y0); wr_y1 = 10'(y1); wr_color = col;
        @(negedge clk);
        wr_en = 1'b0; clear_all = 1'b0;
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    logic [23:0] go_tab [8] = '{24'hC4B4B4, 24'hC8A8A8, 24'hCC9C9C, 24'hD09090,
                                24'hD48484, 24'hD87878, 24'hDC6C6C, 24'hE06060};

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; x = '0; y = '0; active_pixels = 1'b0; frame_start = 1'b0;
        player_x = 10'd600; player_y = 10'd400; lava_x = '0; lava_height = '0;
        game_state = 3'd0; wr_en = 1'b0; wr_idx = '0; wr_valid = 1'b0; clear_all = 1'b0;
        wr_x0 = '0; wr_x1 = '0; wr_y0 = '0; wr_y1 = '0; wr_color = '0;
`ifdef SPRITE_MIRROR_EN
        player_dir = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", 24'h000000, 1'b0);
        rst = 1'b0;

        show("bg_active",   10, 100, 1'b1, 24'hC0C0C0);
        show("bg_inactive", 10, 100, 1'b0, 24'h000000);
        show("ceiling",     10,  50, 1'b1, 24'h404040);

        wr_slot(3, 0, 60, 360, 380, 24'h3CB043, 1'b0);
        wr_slot(5, 50, 100, 350, 370, 24'h505050, 1'b0);
        show("slot_overlap", 55, 365, 1'b1, 24'h505050);
        show("slot3_only",   20, 370, 1'b1, 24'h3CB043);
        wr_slot(3, 0, 60, 360, 380, 24'h3CB043, 1'b1);
        show("clear_wins",   20, 370, 1'b1, 24'hC0C0C0);
        show("slot5_clear",  55, 365, 1'b1, 24'hC0C0C0);
        wr_slot(7, 200, 100, 0, 479, 24'h505050, 1'b0);
        show("inverted_slot", 150, 300, 1'b1, 24'hC0C0C0);

        @(negedge clk); player_x = 10'd100; player_y = 10'd200;
        show("sprite_body", 107, 210, 1'b1, 24'h0000FF);
        show("sprite_gap",  100, 215, 1'b1, 24'hC0C0C0);
        show("sprite_head", 107, 202, 1'b1, 24'h0000FF);
`ifdef SPRITE_MIRROR_EN
        @(negedge clk); player_dir = 1'b1;
        show("mirror_edge", 115, 200, 1'b1, 24'hC0C0C0);
        show("mirror_head", 110, 200, 1'b1, 24'h0000FF);
        @(negedge clk); player_dir = 1'b0;
`endif

        wr_slot(2, 250, 300, 370, 400, 24'hFFD700, 1'b0);
        @(negedge clk); lava_x = 10'd270; lava_height = 10'd100;
        show("lava_hit",      270, 380, 1'b1, 24'hFF4500);
        show("slot_under",    260, 380, 1'b1, 24'hFFD700);
        show("lava_right",    310, 380, 1'b1, 24'hC0C0C0);
        show("lava_left",     269, 479, 1'b1, 24'hC0C0C0);
        show("lava_last_col", 309, 479, 1'b1, 24'hFF4500);
        @(negedge clk); player_x = 10'd265; player_y = 10'd378;
        show("sprite_on_lava", 272, 380, 1'b1, 24'h0000FF);

        @(negedge clk); player_x = 10'd1020; player_y = 10'd200;
        show("nowrap_x1",   1, 200, 1'b1, 24'hC0C0C0);
        show("nowrap_x3",   3, 200, 1'b1, 24'hC0C0C0);
        show("edge_x1023", 1023, 200, 1'b1, 24'hC0C0C0);

        // Game-over fade on a background pixel
        show("pre_fade", 10, 100, 1'b1, 24'hC0C0C0);
        @(negedge clk); game_state = 3'd1;
        frame_pulse();
        settle_chk("fade_enter", 24'hC0C0C0);
        for (int k = 0; k < 8; k++) begin
            frame_pulse();
            settle_chk($sformatf("fade_step%0d", k + 1), go_tab[k]);
        end
        frame_pulse();
        settle_chk("fade_held", 24'hE06060);
        @(negedge clk); game_state = 3'd0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("running_restore", 24'hC0C0C0, 1'b1);

        // GAME_OVER -> WIN mid-fade
        @(negedge clk); game_state = 3'd1;
        frame_pulse(); frame_pulse(); frame_pulse();
        settle_chk("go_mid", 24'hC8A8A8);
        @(negedge clk); game_state = 3'd2;
        settle_chk("win_restart", 24'hC0C0C0);
        for (int k = 0; k < 4; k++) frame_pulse();
        settle_chk("win_half", 24'hD8D0C0);
        for (int k = 0; k < 4; k++) frame_pulse();
        settle_chk("win_full", 24'hF0E0C0);
        frame_pulse();
        settle_chk("win_held", 24'hF0E0C0);
        @(negedge clk); game_state = 3'd0;
        settle_chk("win_exit", 24'hC0C0C0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
